// File: rtl/spi_xfer_seq.sv
// Feeds queued host TX words into the SPI shift register and captures each received character.
// go rises 2 clks after a TX handshake when idle; tx_ready drops when TX is full, launches stall while RX is full.
module spi_xfer_seq #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          tx_valid,
   input  logic [DW-1:0] tx_data,
   output logic          tx_ready,
   output logic          rx_valid,
   output logic [DW-1:0] rx_data,
   input  logic          rx_ready,
   output logic [AW:0]   tx_level,
   output logic [AW:0]   rx_level,
   output logic          busy,
   output logic [3:0]    latch,
   output logic [3:0]    byte_sel,
   output logic [DW-1:0] p_in,
   output logic          go,
   input  logic          tip,
   input  logic [DW-1:0] p_out
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_BUSY,
      S_CAPTURE
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0] tx_mem_q [DEPTH];
   logic [DW-1:0] rx_mem_q [DEPTH];
   logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
   logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          tx_push, tx_pop, rx_push, rx_pop;

   // No pass-through: a full TX FIFO refuses a word even in the cycle it pops.
   assign tx_ready = (tx_cnt_q != FULL);
   assign rx_valid = (rx_cnt_q != '0);
   assign tx_push  = tx_valid && tx_ready;
   assign rx_pop   = rx_valid && rx_ready;
   assign tx_pop   = (state_q == S_LOAD);
   assign rx_push  = (state_q == S_CAPTURE);
   assign tx_level = tx_cnt_q;
   assign rx_level = rx_cnt_q;
   assign rx_data  = rx_mem_q[rx_rd_q];
   assign busy     = (state_q != S_IDLE);

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      if (tx_push && !tx_pop) begin
         tx_cnt_d = tx_cnt_q + ONE;
      end else if (!tx_push && tx_pop) begin
         tx_cnt_d = tx_cnt_q - ONE;
      end
      if (rx_push && !rx_pop) begin
         rx_cnt_d = rx_cnt_q + ONE;
      end else if (!rx_push && rx_pop) begin
         rx_cnt_d = rx_cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push) begin
            tx_mem_q[tx_wr_q] <= tx_data;
            tx_wr_q           <= tx_wr_q + AW'(1);
         end
         if (tx_pop) begin
            tx_rd_q <= tx_rd_q + AW'(1);
         end
         if (rx_push) begin
            rx_mem_q[rx_wr_q] <= p_out;
            rx_wr_q           <= rx_wr_q + AW'(1);
         end
         if (rx_pop) begin
            rx_rd_q <= rx_rd_q + AW'(1);
         end
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Launch only when RX has room for the result, so a capture can never overrun.
   always_comb begin
      state_d  = state_q;
      latch    = 4'b0000;
      byte_sel = 4'h0;
      p_in     = '0;
      go       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (en && (tx_cnt_q != '0) && (rx_cnt_q != FULL) && !tip) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            latch    = 4'b0001;
            byte_sel = 4'hF;
            p_in     = tx_mem_q[tx_rd_q];
            state_d  = S_START;
         end
         S_START: begin
            go = 1'b1;
            if (tip) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!tip) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Randomized scoreboard bench for spi_xfer_seq with a behavioural shift-register model driving tip/p_out.
module tb_spi_xfer_seq;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [31:0] rx_data;
   logic        rx_ready;
   logic [2:0]  tx_level;
   logic [2:0]  rx_level;
   logic        busy;
   logic [3:0]  latch;
   logic [3:0]  byte_sel;
   logic [31:0] p_in;
   logic        go;
   logic        tip;
   logic [31:0] p_out;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_tx[$];
   logic [31:0] exp_rx[$];

   int n_loads = 0;
   int n_go    = 0;
   int n_rx    = 0;
   int go_run  = 0;
   int cur_dly = 0;
   int force_dly = 0;
   bit          pout_force_vld = 0;
   logic [31:0] pout_force = '0;

   spi_xfer_seq #(.DW(32), .DEPTH(4), .AW(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_level (tx_level),
      .rx_level (rx_level),
      .busy     (busy),
      .latch    (latch),
      .byte_sel (byte_sel),
      .p_in     (p_in),
      .go       (go),
      .tip      (tip),
      .p_out    (p_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Shift-register model: tip rises cur_dly cycles after go is seen, stays high a random time,
   // and the received character is presented on p_out as tip falls.
   initial begin : shift_model
      int   phase;
      int   cnt;
      logic g;
      tip   = 1'b0;
      p_out = '0;
      phase = 0;
      cnt   = 0;
      forever begin
         @(negedge clk);
         g = go;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            tip   = 1'b0;
            phase = 0;
         end else if (phase == 0) begin
            if (g) begin
               cur_dly = (force_dly != 0) ? force_dly : int'($urandom_range(1, 4));
               cnt     = cur_dly - 1;
               phase   = 1;
               if (cnt == 0) begin
                  tip   = 1'b1;
                  cnt   = int'($urandom_range(1, 5));
                  phase = 2;
               end
            end
         end else if (phase == 1) begin
            cnt--;
            if (cnt == 0) begin
               tip   = 1'b1;
               cnt   = int'($urandom_range(1, 5));
               phase = 2;
            end
         end else begin
            cnt--;
            if (cnt == 0) begin
               tip   = 1'b0;
               p_out = pout_force_vld ? pout_force : $urandom;
               exp_rx.push_back(p_out);
               phase = 0;
            end
         end
      end
   end

   // Load monitor: each latch pulse must carry the oldest outstanding TX word.
   always @(negedge clk) begin
      if (rst_n && latch[0]) begin
         n_loads++;
         chk("load_tip_low", {31'd0, tip}, 32'd0);
         chk("load_latch", {28'd0, latch}, 32'd1);
         chk("load_byte_sel", {28'd0, byte_sel}, 32'hF);
         chk("load_queue_nonempty", {31'd0, exp_tx.size() != 0}, 32'd1);
         if (exp_tx.size() != 0) begin
            chk("load_p_in", p_in, exp_tx.pop_front());
         end
      end
   end

   // go monitor: one go pulse per load, held until the cycle tip is first seen high.
   always @(negedge clk) begin
      if (!rst_n) begin
         go_run = 0;
      end else if (go) begin
         if (go_run == 0) begin
            n_go++;
            chk("go_per_load", n_go, n_loads);
         end
         go_run++;
      end else if (go_run != 0) begin
         chk("go_width", go_run, cur_dly + 1);
         go_run = 0;
      end
   end

   // RX monitor: popped words must match the shift model's characters in order.
   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) begin
         n_rx++;
         chk("rx_queue_nonempty", {31'd0, exp_rx.size() != 0}, 32'd1);
         if (exp_rx.size() != 0) begin
            chk("rx_data", rx_data, exp_rx.pop_front());
         end
      end
   end

   task automatic step();
      @(negedge clk);
      if (rst_n && tx_valid && tx_ready) begin
         exp_tx.push_back(tx_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      bit done;
      done     = 0;
      tx_valid = 1'b1;
      tx_data  = w;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            exp_tx.push_back(w);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      chk("push_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int i = 0; i < 1000 && quiet < 4; i++) begin
         step();
         quiet = (busy || tip) ? 0 : quiet + 1;
      end
      chk("idle_reached", {31'd0, quiet >= 4}, 32'd1);
   endtask

   task automatic wait_busy_state();
      bit seen;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         step();
         seen = busy && tip && !go;
      end
      chk("busy_state_reached", {31'd0, seen}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_latch"}, {28'd0, latch}, 32'd0);
      chk({tag, "_byte_sel"}, {28'd0, byte_sel}, 32'd0);
      chk({tag, "_p_in"}, p_in, 32'd0);
      chk({tag, "_go"}, {31'd0, go}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
      chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      chk({tag, "_tx_level"}, {29'd0, tx_level}, 32'd0);
      chk({tag, "_rx_level"}, {29'd0, rx_level}, 32'd0);
   endtask

   initial begin : main
      int          base;
      int          rxbase;
      bit          acc;
      bit          seen;
      logic [31:0] w5;

      rst_n    = 1'b0;
      en       = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      chk("reset_rx_data", rx_data, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Single word with exact launch latency.
      en             = 1'b1;
      rx_ready       = 1'b0;
      pout_force     = 32'h1234_5678;
      pout_force_vld = 1;
      tx_valid       = 1'b1;
      tx_data        = 32'hA5C3_0F1E;
      @(negedge clk);
      chk("single_tx_ready", {31'd0, tx_ready}, 32'd1);
      exp_tx.push_back(tx_data);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      @(negedge clk);
      chk("lat_idle_latch", {28'd0, latch}, 32'd0);
      chk("lat_idle_go", {31'd0, go}, 32'd0);
      @(negedge clk);
      chk("lat_load_latch", {28'd0, latch}, 32'd1);
      chk("lat_load_go", {31'd0, go}, 32'd0);
      @(negedge clk);
      chk("lat_start_go", {31'd0, go}, 32'd1);
      @(posedge clk);
      #1;
      wait_idle();
      pout_force_vld = 0;
      chk("single_rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("single_rx_level", {29'd0, rx_level}, 32'd1);
      chk("single_rx_data", rx_data, 32'h1234_5678);
      chk("single_tx_level", {29'd0, tx_level}, 32'd0);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      chk("single_rx_drained", {29'd0, rx_level}, 32'd0);

      // Fill TX while disabled, then drain; fifth word waits for space, no pass-through.
      en       = 1'b0;
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) push($urandom);
      w5       = $urandom;
      tx_valid = 1'b1;
      tx_data  = w5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_tx_ready", {31'd0, tx_ready}, 32'd0);
         chk("full_tx_level", {29'd0, tx_level}, 32'd4);
         @(posedge clk);
         #1;
      end
      en   = 1'b1;
      acc  = 0;
      seen = 0;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         if (latch[0] && !seen) begin
            chk("full_load_no_passthru", {31'd0, tx_ready}, 32'd0);
            seen = 1;
         end
         if (tx_ready) begin
            exp_tx.push_back(w5);
            acc = 1;
         end
         @(posedge clk);
         #1;
      end
      tx_valid = 1'b0;
      chk("fifth_accepted", {31'd0, acc}, 32'd1);
      wait_idle();
      chk("fill_tx_empty", {29'd0, tx_level}, 32'd0);
      chk("fill_rx_empty", {29'd0, rx_level}, 32'd0);
      chk("fill_exp_rx_empty", exp_rx.size(), 32'd0);

      // RX backpressure: six words, only four launch until one RX word is popped.
      rx_ready = 1'b0;
      en       = 1'b0;
      base     = n_loads;
      for (int i = 0; i < 4; i++) push($urandom);
      en = 1'b1;
      for (int i = 0; i < 2; i++) push($urandom);
      wait_idle();
      chk("bp_loads", n_loads - base, 32'd4);
      chk("bp_tx_level", {29'd0, tx_level}, 32'd2);
      chk("bp_rx_level", {29'd0, rx_level}, 32'd4);
      chk("bp_busy", {31'd0, busy}, 32'd0);
      repeat (20) step();
      chk("bp_still_stalled", n_loads - base, 32'd4);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      wait_idle();
      chk("bp_one_more", n_loads - base, 32'd5);
      chk("bp_tx_level_after", {29'd0, tx_level}, 32'd1);
      chk("bp_rx_level_after", {29'd0, rx_level}, 32'd4);
      rx_ready = 1'b1;
      wait_idle();
      chk("bp_drain_tx", {29'd0, tx_level}, 32'd0);
      chk("bp_drain_rx", {29'd0, rx_level}, 32'd0);

      // Fixed 3-cycle tip delay: go must be held exactly 4 cycles.
      force_dly = 3;
      push($urandom);
      push($urandom);
      wait_idle();
      force_dly = 0;

      // Drop en mid-transfer: current word completes, no further launch.
      base   = n_loads;
      rxbase = n_rx;
      push($urandom);
      push($urandom);
      wait_busy_state();
      en = 1'b0;
      wait_idle();
      repeat (10) step();
      chk("endrop_loads", n_loads - base, 32'd1);
      chk("endrop_rx", n_rx - rxbase, 32'd1);
      chk("endrop_tx_level", {29'd0, tx_level}, 32'd1);
      en = 1'b1;
      wait_idle();
      chk("endrop_resume", n_loads - base, 32'd2);

      // Reset asserted while BUSY.
      push($urandom);
      push($urandom);
      push($urandom);
      wait_busy_state();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_tx.delete();
      exp_rx.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push($urandom);
      wait_idle();
      chk("postrst_tx_level", {29'd0, tx_level}, 32'd0);
      chk("postrst_rx_level", {29'd0, rx_level}, 32'd0);

      // Random traffic on all host-side inputs.
      for (int i = 0; i < 400; i++) begin
         tx_valid = 1'($urandom_range(0, 1));
         tx_data  = $urandom;
         rx_ready = ($urandom_range(0, 3) != 0);
         en       = ($urandom_range(0, 7) != 0);
         step();
      end
      tx_valid = 1'b0;
      en       = 1'b1;
      rx_ready = 1'b1;
      wait_idle();
      chk("rand_tx_level", {29'd0, tx_level}, 32'd0);
      chk("rand_rx_level", {29'd0, rx_level}, 32'd0);
      chk("rand_exp_tx_empty", exp_tx.size(), 32'd0);
      chk("rand_exp_rx_empty", exp_rx.size(), 32'd0);
      chk("rand_go_vs_loads", n_go, n_loads);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
